// File: rtl/ctrl_pkg.sv
// Shared definitions for the wait-state control FSM: opcode map, state
// enumeration and the fetch-bus encodings.
package ctrl_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDO = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_LDR = 4'h3;
   localparam logic [3:0] OP_PRE = 4'h4;
   localparam logic [3:0] OP_STO = 4'h5;
   localparam logic [3:0] OP_ADD = 4'h6;
   localparam logic [3:0] OP_SHL = 4'h7;
   localparam logic [3:0] OP_SHR = 4'h8;
   localparam logic [3:0] OP_SUB = 4'h9;
   localparam logic [3:0] OP_INV = 4'hA;
   localparam logic [3:0] OP_AND = 4'hB;
   localparam logic [3:0] OP_OR  = 4'hC;
   localparam logic [3:0] OP_XOR = 4'hD;
   localparam logic [3:0] OP_JMP = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] FETCH_NONE = 2'b00;
   localparam logic [1:0] FETCH_IR   = 2'b01;
   localparam logic [1:0] FETCH_OPND = 2'b10;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      HALT    = 4'd3,
      LFETCH  = 4'd4,
      LDMEM   = 4'd5,
      STREAD  = 4'd6,
      STWRITE = 4'd7,
      SHORT   = 4'd8,
      LDR     = 4'd9,
      JUMP    = 4'd10
   } state_t;

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Wait-state down-counter: loads a hold count on state entry and
// counts down to zero, at which point the owning state may advance.
module ctrl_wait_cnt #(
   parameter int WAIT_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              dec,
   input  logic [WAIT_W-1:0] load_val,
   output logic              zero
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   // next count: load wins over decrement; saturate at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != {WAIT_W{1'b0}})) begin
         cnt_d = cnt_q - WAIT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {WAIT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == {WAIT_W{1'b0}});

endmodule

// File: rtl/ctrl_fsm_ws.sv
// Multi-cycle RISC control FSM with per-memory wait states, latched
// opcode, illegal-opcode trap and resumable halt.
module ctrl_fsm_ws
   import ctrl_pkg::*;
#(
   parameter int OP_W     = 4,
   parameter int ROM_WAIT = 0,
   parameter int RAM_WAIT = 0,
   parameter int WAIT_W   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] ins,
   input  logic            resume,
   output logic            write_r,
   output logic            read_r,
   output logic            pc_en,
   output logic            pc_chg_en,
   output logic [1:0]      fetch,
   output logic            ac_ena,
   output logic            rom_ena,
   output logic            rom_read,
   output logic            ram_ena,
   output logic            ram_read,
   output logic            ram_write,
   output logic            ad_sel,
   output logic            halted,
   output logic            illegal
);

   localparam logic [WAIT_W-1:0] ROM_LD = WAIT_W'(ROM_WAIT);
   localparam logic [WAIT_W-1:0] RAM_LD = WAIT_W'(RAM_WAIT);

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              cnt_zero;
   logic              cnt_load;
   logic [WAIT_W-1:0] cnt_val;
   logic              ins_ext;
   logic              op_legal;

   assign ins_ext  = |(ins >> 4);
   assign op_legal = ~|(op_q >> 4);

   // state and latched opcode
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= {OP_W{1'b0}};
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // next state, opcode capture and illegal-opcode trap
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      illegal = 1'b0;
      case (state_q)
         IDLE:   state_d = FETCH;
         FETCH:  state_d = cnt_zero ? DECODE : FETCH;
         DECODE: begin
            op_d = ins;
            if (ins_ext) begin
               state_d = FETCH;
               illegal = 1'b1;
            end else begin
               case (ins[3:0])
                  OP_NOP:                         state_d = FETCH;
                  OP_HLT:                         state_d = HALT;
                  OP_LDR:                         state_d = LDR;
                  OP_LDO, OP_LDA, OP_STO, OP_JMP: state_d = LFETCH;
                  default:                        state_d = SHORT;
               endcase
            end
         end
         LFETCH: begin
            if (cnt_zero && op_legal) begin
               case (op_q[3:0])
                  OP_JMP:         state_d = JUMP;
                  OP_LDO, OP_LDA: state_d = LDMEM;
                  OP_STO:         state_d = STREAD;
                  default:        state_d = FETCH;
               endcase
            end else if (cnt_zero) begin
               state_d = FETCH;
            end else begin
               state_d = LFETCH;
            end
         end
         STREAD:                 state_d = STWRITE;
         LDMEM, STWRITE:         state_d = cnt_zero ? FETCH : state_q;
         SHORT, LDR, JUMP:       state_d = FETCH;
         HALT:                   state_d = resume ? FETCH : HALT;
         default:                state_d = IDLE;
      endcase
   end

   // wait count loaded on every state change, chosen by the memory the new state touches
   always_comb begin
      cnt_load = (state_d != state_q);
      case (state_d)
         FETCH, LFETCH: cnt_val = ROM_LD;
         LDMEM:         cnt_val = (op_q[3:0] == OP_LDA) ? RAM_LD : ROM_LD;
         STWRITE:       cnt_val = RAM_LD;
         default:       cnt_val = {WAIT_W{1'b0}};
      endcase
   end

   ctrl_wait_cnt #(
      .WAIT_W   (WAIT_W)
   ) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (1'b1),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   // Moore strobe decode; single-cycle strobes only fire on the last wait cycle
   always_comb begin
      write_r   = 1'b0;
      read_r    = 1'b0;
      pc_en     = 1'b0;
      pc_chg_en = 1'b0;
      fetch     = FETCH_NONE;
      ac_ena    = 1'b0;
      rom_ena   = 1'b0;
      rom_read  = 1'b0;
      ram_ena   = 1'b0;
      ram_read  = 1'b0;
      ram_write = 1'b0;
      ad_sel    = 1'b0;
      halted    = 1'b0;
      case (state_q)
         FETCH: begin
            rom_ena  = 1'b1;
            rom_read = 1'b1;
            fetch    = FETCH_IR;
         end
         DECODE: pc_en = 1'b1;
         LFETCH: begin
            rom_ena  = 1'b1;
            rom_read = 1'b1;
            fetch    = FETCH_OPND;
         end
         LDMEM: begin
            ad_sel  = 1'b1;
            write_r = cnt_zero;
            pc_en   = cnt_zero;
            if (op_q[3:0] == OP_LDA) begin
               ram_ena  = 1'b1;
               ram_read = 1'b1;
            end else begin
               rom_ena  = 1'b1;
               rom_read = 1'b1;
            end
         end
         STREAD: begin
            read_r = 1'b1;
            pc_en  = 1'b1;
         end
         STWRITE: begin
            read_r    = 1'b1;
            ad_sel    = 1'b1;
            ram_ena   = 1'b1;
            ram_write = 1'b1;
         end
         SHORT: begin
            read_r = 1'b1;
            ac_ena = 1'b1;
         end
         LDR: begin
            write_r = 1'b1;
            ac_ena  = 1'b1;
         end
         JUMP: begin
            pc_en     = 1'b1;
            pc_chg_en = 1'b1;
         end
         HALT:    halted = 1'b1;
         default: halted = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ctrl_fsm_ws.sv
// Scoreboard bench: the driver expands each instruction into its expected
// per-cycle strobe trace; a negedge monitor pops and compares every cycle.
module tb_ctrl_fsm_ws;

   localparam int OP_W  = 6;
   localparam int ROM_W = 1;
   localparam int RAM_W = 2;

   localparam logic [14:0] W_R  = 15'h4000;
   localparam logic [14:0] R_R  = 15'h2000;
   localparam logic [14:0] PCE  = 15'h1000;
   localparam logic [14:0] PCC  = 15'h0800;
   localparam logic [14:0] F_OP = 15'h0400;
   localparam logic [14:0] F_IR = 15'h0200;
   localparam logic [14:0] ACE  = 15'h0100;
   localparam logic [14:0] ROME = 15'h0080;
   localparam logic [14:0] ROMR = 15'h0040;
   localparam logic [14:0] RAME = 15'h0020;
   localparam logic [14:0] RAMR = 15'h0010;
   localparam logic [14:0] RAMW = 15'h0008;
   localparam logic [14:0] ADS  = 15'h0004;
   localparam logic [14:0] HLTD = 15'h0002;
   localparam logic [14:0] ILL  = 15'h0001;
   localparam logic [14:0] NONE = 15'h0000;

   logic            clk = 1'b0;
   logic            rst;
   logic [OP_W-1:0] ins;
   logic            resume;
   logic write_r, read_r, pc_en, pc_chg_en, ac_ena, rom_ena, rom_read;
   logic ram_ena, ram_read, ram_write, ad_sel, halted, illegal;
   logic [1:0] fetch;
   logic [14:0] act;

   logic [14:0] exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc_no   = 0;

   ctrl_fsm_ws #(
      .OP_W(OP_W), .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .WAIT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .ins(ins), .resume(resume),
      .write_r(write_r), .read_r(read_r), .pc_en(pc_en), .pc_chg_en(pc_chg_en),
      .fetch(fetch), .ac_ena(ac_ena), .rom_ena(rom_ena), .rom_read(rom_read),
      .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
      .ad_sel(ad_sel), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   assign act = {write_r, read_r, pc_en, pc_chg_en, fetch, ac_ena, rom_ena, rom_read,
                 ram_ena, ram_read, ram_write, ad_sel, halted, illegal};

   // monitor: one expected vector per driven cycle
   always @(negedge clk) begin
      logic [14:0] e;
      string       t;
      cyc_no++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n_checks++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s cycle %0d: outputs %h, required %h", t, cyc_no, act, e);
         end
      end
   end

   // one clock: drive inputs for the edge ending this cycle, queue this cycle's outputs
   task automatic step(input logic [14:0] e, input string t, input bit r,
                       input bit dec, input logic [OP_W-1:0] op, input int res);
      @(posedge clk);
      #1;
      rst    = r;
      ins    = dec ? op : OP_W'($urandom);
      resume = (res < 0) ? 1'($urandom) : 1'(res);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic st(input logic [14:0] e, input string t);
      step(e, t, 1'b0, 1'b0, '0, -1);
   endtask

   // expected trace of a whole instruction; rst_k >= 0 resets on that STWRITE cycle
   task automatic run_instr(input logic [OP_W-1:0] op, input int hold, input int rst_k);
      for (int i = 0; i <= ROM_W; i++) st(ROME | ROMR | F_IR, "fetch");
      step(PCE | ((op[OP_W-1:4] != '0) ? ILL : NONE), "decode", 1'b0, 1'b1, op, -1);
      if (op[OP_W-1:4] != '0) return;
      case (op[3:0])
         4'h0: ;
         4'hF: begin
            for (int i = 0; i < hold; i++) step(HLTD, "halt_hold", 1'b0, 1'b0, '0, 0);
            step(HLTD, "halt_resume", 1'b0, 1'b0, '0, 1);
         end
         4'h3: st(W_R | ACE, "ldr");
         4'h1, 4'h2, 4'h5, 4'hE: begin
            for (int i = 0; i <= ROM_W; i++) st(ROME | ROMR | F_OP, "lfetch");
            if (op[3:0] == 4'hE) begin
               st(PCE | PCC, "jump");
            end else if (op[3:0] == 4'h1) begin
               for (int i = 0; i <= ROM_W; i++)
                  st(ADS | ROME | ROMR | ((i == ROM_W) ? (W_R | PCE) : NONE), "ldmem_ldo");
            end else if (op[3:0] == 4'h2) begin
               for (int i = 0; i <= RAM_W; i++)
                  st(ADS | RAME | RAMR | ((i == RAM_W) ? (W_R | PCE) : NONE), "ldmem_lda");
            end else begin
               st(R_R | PCE, "stread");
               for (int i = 0; i <= RAM_W; i++) begin
                  step(R_R | ADS | RAME | RAMW, "stwrite", (i == rst_k), 1'b0, '0, -1);
                  if (i == rst_k) begin
                     st(NONE, "post_reset_idle");
                     return;
                  end
               end
            end
         end
         default: st(R_R | ACE, "short");
      endcase
   endtask

   initial begin
      logic [OP_W-1:0] op;
      rst    = 1'b1;
      ins    = '0;
      resume = 1'b0;
      @(posedge clk);
      step(NONE, "reset", 1'b1, 1'b0, '0, 0);
      step(NONE, "idle", 1'b0, 1'b0, '0, 0);

      run_instr(6'h00, 0, -1);   // NOP
      run_instr(6'h02, 0, -1);   // LDA
      run_instr(6'h05, 0, -1);   // STO
      run_instr(6'h0F, 10, -1);  // HLT held
      run_instr(6'h15, 0, -1);   // extended opcode trap
      run_instr(6'h01, 0, -1);   // LDO
      run_instr(6'h0E, 0, -1);   // JMP
      run_instr(6'h03, 0, -1);   // LDR
      run_instr(6'h04, 0, -1);   // short
      run_instr(6'h05, 0, 1);    // STO reset mid-STWRITE

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) op = OP_W'($urandom) | 6'h10;
         else op = {2'b00, 4'($urandom)};
         run_instr(op, $urandom_range(0, 4), ($urandom_range(0, 15) == 0) ? $urandom_range(0, RAM_W) : -1);
      end

      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
